// File: rtl/operand_screen_pkg.sv
// rtl/operand_screen_pkg.sv - shared FSM encoding, counter sizing and flag bundle for operand_screen
package operand_screen_pkg;

   // Screen controller states; encodings are fixed so the multdiv controller can decode them
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Per-operand classification result
   typedef struct packed {
      logic zero;
      logic ones;
      logic min;
   } op_class_t;

   // Chunk counter width; a single-chunk scan still needs a 1-bit counter
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/operand_screen_if.sv
// rtl/operand_screen_if.sv - request/result bundle between the multdiv controller and operand_screen
interface operand_screen_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op_div;
   logic [WIDTH-1:0] operandA;
   logic [WIDTH-1:0] operandB;
   logic             busy;
   logic             done;
   logic             a_zero;
   logic             b_zero;
   logic             a_ones;
   logic             b_ones;
   logic             a_min;
   logic             b_min;
   logic             div_by_zero;
   logic             div_overflow;
   logic             mult_trivial;

   modport master (
      output start, op_div, operandA, operandB,
      input  busy, done, a_zero, b_zero, a_ones, b_ones, a_min, b_min,
             div_by_zero, div_overflow, mult_trivial
   );

   modport slave (
      input  start, op_div, operandA, operandB,
      output busy, done, a_zero, b_zero, a_ones, b_ones, a_min, b_min,
             div_by_zero, div_overflow, mult_trivial
   );
endinterface

// File: rtl/operand_screen_chunk_classify.sv
// rtl/operand_screen_chunk_classify.sv - combinational all-ones / all-zero test of one operand chunk
module chunk_classify #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] chunk_in,
   output logic             all_ones,
   output logic             all_zero
);

   // Plain reductions over the chunk
   always_comb begin
      all_ones = &chunk_in;
      all_zero = ~|chunk_in;
   end

endmodule

// File: rtl/operand_screen.sv
// rtl/operand_screen.sv - multi-cycle zero / minus-one / INT_MIN operand classifier for multdiv
module operand_screen
   import operand_screen_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input logic              clock,
   input logic              reset,
   operand_screen_if.slave  bus
);

   localparam int                NCHUNK   = WIDTH / CHUNK;
   localparam int                CNT_W    = cnt_width(NCHUNK);
   localparam logic [CNT_W-1:0]  LAST     = CNT_W'(NCHUNK - 1);
   // Every bit of a chunk except its MSB; used on the top chunk where the MSB is the sign bit
   localparam logic [CHUNK-1:0]  LOW_MASK = CHUNK'((64'd1 << (CHUNK - 1)) - 64'd1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             op_div_q, op_div_d;

   // Running accumulators: all chunks so far ones / zero, and bits below the sign bit zero
   logic             a_ones_acc_q, a_ones_acc_d, b_ones_acc_q, b_ones_acc_d;
   logic             a_zero_acc_q, a_zero_acc_d, b_zero_acc_q, b_zero_acc_d;
   logic             a_low_acc_q,  a_low_acc_d,  b_low_acc_q,  b_low_acc_d;

   op_class_t        a_cls_q, a_cls_d;
   op_class_t        b_cls_q, b_cls_d;

   logic [CHUNK-1:0] a_chunk, b_chunk;
   logic             a_chunk_ones, a_chunk_zero, b_chunk_ones, b_chunk_zero;
   logic             a_low_step, b_low_step;
   logic             is_last;
   logic             accept;

   // Pick the chunk addressed by the counter from the latched operands
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (count_q == CNT_W'(i)) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   chunk_classify #(.CHUNK(CHUNK)) u_cls_a (
      .chunk_in (a_chunk),
      .all_ones (a_chunk_ones),
      .all_zero (a_chunk_zero)
   );

   chunk_classify #(.CHUNK(CHUNK)) u_cls_b (
      .chunk_in (b_chunk),
      .all_ones (b_chunk_ones),
      .all_zero (b_chunk_zero)
   );

   // Lower-zero contribution: whole chunk normally, sign bit excluded on the top chunk
   always_comb begin
      is_last    = (count_q == LAST);
      a_low_step = is_last ? ~|(a_chunk & LOW_MASK) : a_chunk_zero;
      b_low_step = is_last ? ~|(b_chunk & LOW_MASK) : b_chunk_zero;
      accept     = bus.start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   end

   // Next-state, operand latch, accumulator fold and final flag capture
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      a_d          = a_q;
      b_d          = b_q;
      op_div_d     = op_div_q;
      a_ones_acc_d = a_ones_acc_q;
      a_zero_acc_d = a_zero_acc_q;
      a_low_acc_d  = a_low_acc_q;
      b_ones_acc_d = b_ones_acc_q;
      b_zero_acc_d = b_zero_acc_q;
      b_low_acc_d  = b_low_acc_q;
      a_cls_d      = a_cls_q;
      b_cls_d      = b_cls_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               state_d      = ST_SCAN;
               count_d      = '0;
               a_d          = bus.operandA;
               b_d          = bus.operandB;
               op_div_d     = bus.op_div;
               a_ones_acc_d = 1'b1;
               a_zero_acc_d = 1'b1;
               a_low_acc_d  = 1'b1;
               b_ones_acc_d = 1'b1;
               b_zero_acc_d = 1'b1;
               b_low_acc_d  = 1'b1;
               a_cls_d      = '0;
               b_cls_d      = '0;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_SCAN: begin
            a_ones_acc_d = a_ones_acc_q & a_chunk_ones;
            a_zero_acc_d = a_zero_acc_q & a_chunk_zero;
            a_low_acc_d  = a_low_acc_q  & a_low_step;
            b_ones_acc_d = b_ones_acc_q & b_chunk_ones;
            b_zero_acc_d = b_zero_acc_q & b_chunk_zero;
            b_low_acc_d  = b_low_acc_q  & b_low_step;
            if (is_last) begin
               state_d      = ST_DONE;
               a_cls_d.zero = a_zero_acc_d;
               a_cls_d.ones = a_ones_acc_d;
               a_cls_d.min  = a_q[WIDTH-1] & a_low_acc_d;
               b_cls_d.zero = b_zero_acc_d;
               b_cls_d.ones = b_ones_acc_d;
               b_cls_d.min  = b_q[WIDTH-1] & b_low_acc_d;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset clears everything so all outputs read 0
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_div_q     <= 1'b0;
         a_ones_acc_q <= 1'b0;
         a_zero_acc_q <= 1'b0;
         a_low_acc_q  <= 1'b0;
         b_ones_acc_q <= 1'b0;
         b_zero_acc_q <= 1'b0;
         b_low_acc_q  <= 1'b0;
         a_cls_q      <= '0;
         b_cls_q      <= '0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_div_q     <= op_div_d;
         a_ones_acc_q <= a_ones_acc_d;
         a_zero_acc_q <= a_zero_acc_d;
         a_low_acc_q  <= a_low_acc_d;
         b_ones_acc_q <= b_ones_acc_d;
         b_zero_acc_q <= b_zero_acc_d;
         b_low_acc_q  <= b_low_acc_d;
         a_cls_q      <= a_cls_d;
         b_cls_q      <= b_cls_d;
      end
   end

   // Outputs decode registered state only; derived flags gate on the latched op_div
   always_comb begin
      bus.busy         = (state_q == ST_SCAN);
      bus.done         = (state_q == ST_DONE);
      bus.a_zero       = a_cls_q.zero;
      bus.b_zero       = b_cls_q.zero;
      bus.a_ones       = a_cls_q.ones;
      bus.b_ones       = b_cls_q.ones;
      bus.a_min        = a_cls_q.min;
      bus.b_min        = b_cls_q.min;
      bus.div_by_zero  = op_div_q & b_cls_q.zero;
      bus.div_overflow = op_div_q & a_cls_q.min & b_cls_q.ones;
      bus.mult_trivial = ~op_div_q & (a_cls_q.zero | b_cls_q.zero | a_cls_q.ones | b_cls_q.ones);
   end

endmodule

// File: tb/tb_operand_screen.sv
// tb/tb_operand_screen.sv - randomized self-checking bench for operand_screen, CHUNK=8 and CHUNK=32
module tb_operand_screen;

   logic clk;
   logic rst;

   int n_vec = 0;
   int n_err = 0;

   logic        start_v [2];
   logic        opd_v   [2];
   logic [31:0] a_v     [2];
   logic [31:0] b_v     [2];
   logic        busy_v  [2];
   logic        done_v  [2];
   logic [8:0]  flags_v [2];

   operand_screen_if #(.WIDTH(32)) if8 ();
   operand_screen_if #(.WIDTH(32)) if32 ();

   operand_screen #(.WIDTH(32), .CHUNK(8)) u_dut8 (
      .clock (clk),
      .reset (rst),
      .bus   (if8)
   );

   operand_screen #(.WIDTH(32), .CHUNK(32)) u_dut32 (
      .clock (clk),
      .reset (rst),
      .bus   (if32)
   );

   assign if8.start     = start_v[0];
   assign if8.op_div    = opd_v[0];
   assign if8.operandA  = a_v[0];
   assign if8.operandB  = b_v[0];
   assign if32.start    = start_v[1];
   assign if32.op_div   = opd_v[1];
   assign if32.operandA = a_v[1];
   assign if32.operandB = b_v[1];

   assign busy_v[0]  = if8.busy;
   assign done_v[0]  = if8.done;
   assign flags_v[0] = {if8.a_zero, if8.b_zero, if8.a_ones, if8.b_ones, if8.a_min, if8.b_min,
                        if8.div_by_zero, if8.div_overflow, if8.mult_trivial};
   assign busy_v[1]  = if32.busy;
   assign done_v[1]  = if32.done;
   assign flags_v[1] = {if32.a_zero, if32.b_zero, if32.a_ones, if32.b_ones, if32.a_min, if32.b_min,
                        if32.div_by_zero, if32.div_overflow, if32.mult_trivial};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference classification straight from the operand values
   function automatic logic [8:0] model(input logic [31:0] a, input logic [31:0] b, input logic d);
      logic az, bz, ao, bo, am, bm;
      az = (a == 32'd0);
      bz = (b == 32'd0);
      ao = (a == 32'hFFFF_FFFF);
      bo = (b == 32'hFFFF_FFFF);
      am = (a == 32'h8000_0000);
      bm = (b == 32'h8000_0000);
      return {az, bz, ao, bo, am, bm, d & bz, d & am & bo, ~d & (az | bz | ao | bo)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_screen(input int sel, input logic [31:0] a, input logic [31:0] b, input logic d);
      a_v[sel]     = a;
      b_v[sel]     = b;
      opd_v[sel]   = d;
      start_v[sel] = 1'b1;
   endtask

   // Called at the negedge of the accept cycle; returns at the negedge of the done cycle
   task automatic wait_done(input int sel, input logic [8:0] exp, input bit repulse, input bit b2b);
      int lat;
      int seen;
      lat  = (sel == 0) ? 5 : 2;
      seen = 0;
      for (int cyc = 1; cyc <= 30 && seen == 0; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            start_v[sel] = 1'b0;
            a_v[sel]     = $urandom;
            b_v[sel]     = $urandom;
            opd_v[sel]   = ~opd_v[sel];
            check("busy_after_accept", 32'(busy_v[sel]), 32'd1);
            if (b2b) begin
               check("b2b_done_fell", 32'(done_v[sel]), 32'd0);
               check("b2b_flags_cleared", 32'(flags_v[sel]), 32'd0);
            end
         end
         if (repulse && cyc == 2) begin
            start_v[sel] = 1'b1;
            a_v[sel]     = 32'd0;
            b_v[sel]     = 32'd0;
         end
         if (repulse && cyc == 3) start_v[sel] = 1'b0;
         check("busy_done_excl", 32'(busy_v[sel] & done_v[sel]), 32'd0);
         if (done_v[sel]) seen = cyc;
      end
      check("done_latency", 32'(seen), 32'(lat));
      check("flags_at_done", 32'(flags_v[sel]), 32'(exp));
   endtask

   task automatic idle_check(input int sel, input logic [8:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_no_done", 32'(done_v[sel]), 32'd0);
         check("idle_not_busy", 32'(busy_v[sel]), 32'd0);
         check("flags_hold", 32'(flags_v[sel]), 32'(exp));
      end
   endtask

   task automatic run(input int sel, input logic [31:0] a, input logic [31:0] b, input logic d,
                      input bit repulse);
      logic [8:0] exp;
      exp = model(a, b, d);
      start_screen(sel, a, b, d);
      wait_done(sel, exp, repulse, 1'b0);
      idle_check(sel, exp, 2);
   endtask

   task automatic run_b2b(input int sel, input logic [31:0] a0, input logic [31:0] b0, input logic d0,
                          input logic [31:0] a1, input logic [31:0] b1, input logic d1);
      start_screen(sel, a0, b0, d0);
      wait_done(sel, model(a0, b0, d0), 1'b0, 1'b0);
      start_screen(sel, a1, b1, d1);
      wait_done(sel, model(a1, b1, d1), 1'b0, 1'b1);
      idle_check(sel, model(a1, b1, d1), 2);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'd1 << $urandom_range(0, 31);
         5: return ~(32'd1 << $urandom_range(0, 31));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int s = 0; s < 2; s++) begin
         start_v[s] = 1'b0;
         opd_v[s]   = 1'b0;
         a_v[s]     = '0;
         b_v[s]     = '0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         check("reset_busy", 32'(busy_v[s]), 32'd0);
         check("reset_done", 32'(done_v[s]), 32'd0);
         check("reset_flags", 32'(flags_v[s]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      for (int s = 0; s < 2; s++) begin
         run(s, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
         run(s, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
         run(s, 32'hFFFF_FFFE, 32'h1234_5678, 1'b0, 1'b0);
         run(s, 32'h7FFF_FFFF, 32'h1234_5678, 1'b0, 1'b0);
         run(s, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0);
         run(s, 32'h8000_0001, 32'h8000_0000, 1'b1, 1'b0);
         run_b2b(s, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
      end

      run(0, 32'h1111_2222, 32'hFFFF_FFFF, 1'b1, 1'b1);

      start_screen(0, 32'hFFFF_FFFF, 32'd0, 1'b1);
      @(negedge clk);
      start_v[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_abort_busy", 32'(busy_v[0]), 32'd0);
      check("reset_abort_done", 32'(done_v[0]), 32'd0);
      check("reset_abort_flags", 32'(flags_v[0]), 32'd0);
      rst = 1'b0;
      idle_check(0, 9'd0, 6);
      run(0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);

      start_screen(1, 32'd0, 32'd0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("reset_over_start_busy", 32'(busy_v[1]), 32'd0);
      check("reset_over_start_flags", 32'(flags_v[1]), 32'd0);
      start_v[1] = 1'b0;
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 60; i++) begin
         int          s;
         logic [31:0] a0, b0, a1, b1;
         logic        d0, d1;
         s  = $urandom_range(0, 1);
         a0 = pick();
         b0 = pick();
         d0 = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            a1 = pick();
            b1 = pick();
            d1 = 1'($urandom_range(0, 1));
            run_b2b(s, a0, b0, d0, a1, b1, d1);
         end else begin
            run(s, a0, b0, d0, (s == 0) && ($urandom_range(0, 3) == 0));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
